// File: rtl/idu_pkg.sv
// Shared opcodes, mnemonic and format encodings, and the control bundle for idu_pipe.
package idu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [5:0] {
    ILLEGAL,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  } mnem_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
  } fmt_e;

  // Decoded control bundle handed to execute.
  typedef struct packed {
    mnem_e mnem;
    logic  illegal;
    logic  rd_wr;
    logic  dm_oe;
    logic  alu_src1;
    logic  alu_src2;
  } ctrl_t;

  function automatic fmt_e fmt_of(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_OP:                        f = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: f = FMT_I;
      OPC_STORE:                     f = FMT_S;
      OPC_BRANCH:                    f = FMT_B;
      OPC_LUI, OPC_AUIPC:            f = FMT_U;
      OPC_JAL:                       f = FMT_J;
      default:                       f = FMT_X;
    endcase
    return f;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    fmt_e f;
    f = fmt_of(opc);
    return (f == FMT_R) || (f == FMT_I) || (f == FMT_S) || (f == FMT_B);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    fmt_e f;
    f = fmt_of(opc);
    return (f == FMT_R) || (f == FMT_S) || (f == FMT_B);
  endfunction

endpackage

// File: rtl/idu_regfile.sv
// Architectural register file with x0 hardwired to zero.
// Optional same-cycle write-back bypass enabled by IDU_RF_BYPASS_EN.
module idu_regfile
  import idu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_NUM = 32,
  localparam int unsigned RA_W   = $clog2(REG_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [RA_W-1:0] wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [RA_W-1:0] rs1_addr,
  input  logic [RA_W-1:0] rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0] regs [REG_NUM];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(REG_NUM); i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Without the bypass, a same-cycle read sees the pre-write value.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`ifdef IDU_RF_BYPASS_EN
    if (wr_en && (wr_addr == rs1_addr) && (rs1_addr != '0)) rs1_data = wr_data;
    if (wr_en && (wr_addr == rs2_addr) && (rs2_addr != '0)) rs2_data = wr_data;
`endif
  end

endmodule

// File: rtl/idu_pipe.sv
// Handshaked decode stage: one-entry stage register, decode, load-use stall, flush.
// Register-file bypass is selected by IDU_RF_BYPASS_EN (see idu_regfile).
module idu_pipe
  import idu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned MNEM_W  = 6,
  localparam int unsigned RA_W   = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [31:0]       i_inst,
  input  logic              i_flush,
  input  logic              i_ready,
  output logic              o_valid,
  input  logic              i_ex_load,
  input  logic [RA_W-1:0]   i_ex_rd_addr,
  input  logic              i_rd_wr,
  input  logic [RA_W-1:0]   i_rd_addr,
  input  logic [XLEN-1:0]   i_rd_data,
  output logic [XLEN-1:0]   o_pc,
  output logic [MNEM_W-1:0] o_mnemonic,
  output logic [RA_W-1:0]   o_rs1_addr,
  output logic [RA_W-1:0]   o_rs2_addr,
  output logic [RA_W-1:0]   o_rd_addr,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic [XLEN-1:0]   o_imm,
  output logic              o_rd_wr,
  output logic              o_ALUsrc1,
  output logic              o_ALUsrc2,
  output logic              o_DM_OE,
  output logic              o_illegal,
  output logic              o_hazard
);

  logic            hv;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RA_W-1:0] rs1;
  logic [RA_W-1:0] rs2;
  logic            hazard;
  fmt_e            fmt;
  mnem_e           mnem;
  ctrl_t           ctrl;
  logic [31:0]     imm32;

  assign opcode = inst_q[6:0];
  assign funct3 = inst_q[14:12];
  assign funct7 = inst_q[31:25];
  assign rs1    = RA_W'(inst_q[19:15]);
  assign rs2    = RA_W'(inst_q[24:20]);
  assign fmt    = fmt_of(opcode);

  // Load-use stall: the held instruction needs a register the load in execute has not produced yet.
  assign hazard = hv && i_ex_load && (i_ex_rd_addr != '0) &&
                  ((uses_rs1(opcode) && (rs1 == i_ex_rd_addr)) ||
                   (uses_rs2(opcode) && (rs2 == i_ex_rd_addr)));

  assign o_hazard = hazard;
  assign o_valid  = hv && !hazard;
  assign o_ready  = !hv || (i_ready && !hazard);

  // Stage register; flush overrides any accept in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hv     <= 1'b0;
      pc_q   <= '0;
      inst_q <= NOP;
    end else if (i_flush) begin
      hv <= 1'b0;
    end else if (i_valid && o_ready) begin
      hv     <= 1'b1;
      pc_q   <= i_pc;
      inst_q <= i_inst;
    end else if (o_valid && i_ready) begin
      hv <= 1'b0;
    end
  end

  // Mnemonic decode; anything not recognised falls through to ILLEGAL.
  always_comb begin
    mnem = ILLEGAL;
    case (opcode)
      OPC_LUI:   mnem = LUI;
      OPC_AUIPC: mnem = AUIPC;
      OPC_JAL:   mnem = JAL;
      OPC_JALR:  mnem = (funct3 == 3'd0) ? JALR : ILLEGAL;
      OPC_BRANCH: begin
        case (funct3)
          3'd0:    mnem = BEQ;
          3'd1:    mnem = BNE;
          3'd4:    mnem = BLT;
          3'd5:    mnem = BGE;
          3'd6:    mnem = BLTU;
          3'd7:    mnem = BGEU;
          default: mnem = ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        case (funct3)
          3'd0:    mnem = LB;
          3'd1:    mnem = LH;
          3'd2:    mnem = LW;
          3'd4:    mnem = LBU;
          3'd5:    mnem = LHU;
          default: mnem = ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'd0:    mnem = SB;
          3'd1:    mnem = SH;
          3'd2:    mnem = SW;
          default: mnem = ILLEGAL;
        endcase
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'd0: mnem = ADDI;
          3'd1: mnem = (funct7 == 7'h00) ? SLLI : ILLEGAL;
          3'd2: mnem = SLTI;
          3'd3: mnem = SLTIU;
          3'd4: mnem = XORI;
          3'd5: begin
            if (funct7 == 7'h00)      mnem = SRLI;
            else if (funct7 == 7'h20) mnem = SRAI;
            else                      mnem = ILLEGAL;
          end
          3'd6: mnem = ORI;
          default: mnem = ANDI;
        endcase
      end
      OPC_OP: begin
        case ({funct7, funct3})
          {7'h00, 3'd0}: mnem = ADD;
          {7'h20, 3'd0}: mnem = SUB;
          {7'h00, 3'd1}: mnem = SLL;
          {7'h00, 3'd2}: mnem = SLT;
          {7'h00, 3'd3}: mnem = SLTU;
          {7'h00, 3'd4}: mnem = XOR;
          {7'h00, 3'd5}: mnem = SRL;
          {7'h20, 3'd5}: mnem = SRA;
          {7'h00, 3'd6}: mnem = OR;
          {7'h00, 3'd7}: mnem = AND;
          default:       mnem = ILLEGAL;
        endcase
      end
      default: mnem = ILLEGAL;
    endcase
  end

  // Control lines: ALU src1 selects PC, src2 selects the immediate.
  always_comb begin
    ctrl          = '0;
    ctrl.mnem     = mnem;
    ctrl.illegal  = (mnem == ILLEGAL);
    if (!ctrl.illegal) begin
      ctrl.rd_wr    = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
      ctrl.dm_oe    = (opcode == OPC_LOAD);
      ctrl.alu_src1 = (opcode == OPC_AUIPC) || (opcode == OPC_JAL);
      ctrl.alu_src2 = (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_U) || (fmt == FMT_J);
    end
  end

  // Immediate assembly per format; sign comes from inst[31].
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{inst_q[31]}}, inst_q[31:20]};
      FMT_S:   imm32 = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      FMT_B:   imm32 = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
      FMT_U:   imm32 = {inst_q[31:12], 12'h000};
      FMT_J:   imm32 = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  idu_regfile #(
    .XLEN    (XLEN),
    .REG_NUM (REG_NUM)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (i_rd_wr),
    .wr_addr  (i_rd_addr),
    .wr_data  (i_rd_data),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (o_rs1_data),
    .rs2_data (o_rs2_data)
  );

  assign o_pc       = pc_q;
  assign o_mnemonic = MNEM_W'(ctrl.mnem);
  assign o_rs1_addr = rs1;
  assign o_rs2_addr = rs2;
  assign o_rd_addr  = RA_W'(inst_q[11:7]);
  assign o_imm      = XLEN'($signed(imm32));
  assign o_rd_wr    = ctrl.rd_wr;
  assign o_ALUsrc1  = ctrl.alu_src1;
  assign o_ALUsrc2  = ctrl.alu_src2;
  assign o_DM_OE    = ctrl.dm_oe;
  assign o_illegal  = ctrl.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: directed steps then random traffic against a table-driven decode model.
module tb_idu_pipe;
  import idu_pkg::*;

  localparam int unsigned XLEN = 32, REG_NUM = 32, MNEM_W = 6, RA_W = 5;

  logic clk = 1'b0;
  logic rst;
  logic valid, flush, rdy, ex_load, wb_wr;
  logic [31:0] pc, inst, wb_data;
  logic [4:0] ex_rd, wb_addr;

  logic o_ready, o_valid, o_rd_wr, o_ALUsrc1, o_ALUsrc2, o_DM_OE, o_illegal, o_hazard;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [5:0] o_mnemonic;
  logic [4:0] o_rs1_addr, o_rs2_addr, o_rd_addr;

  always #5 clk = ~clk;

  idu_pipe #(.XLEN(XLEN), .REG_NUM(REG_NUM), .MNEM_W(MNEM_W)) dut (
    .clk(clk), .rst(rst), .i_valid(valid), .o_ready(o_ready), .i_pc(pc), .i_inst(inst),
    .i_flush(flush), .i_ready(rdy), .o_valid(o_valid), .i_ex_load(ex_load),
    .i_ex_rd_addr(ex_rd), .i_rd_wr(wb_wr), .i_rd_addr(wb_addr), .i_rd_data(wb_data),
    .o_pc(o_pc), .o_mnemonic(o_mnemonic), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .o_rd_addr(o_rd_addr), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
    .o_rd_wr(o_rd_wr), .o_ALUsrc1(o_ALUsrc1), .o_ALUsrc2(o_ALUsrc2), .o_DM_OE(o_DM_OE),
    .o_illegal(o_illegal), .o_hazard(o_hazard)
  );

  // fmt: 0=R 1=I 2=S 3=B 4=U 5=J
  typedef struct { logic [31:0] mask; logic [31:0] match; mnem_e mn; int fmt; } pat_t;
  pat_t pats[$];

  int checks = 0, errors = 0;
  logic        m_hv;
  logic [31:0] m_pc, m_inst;
  logic [31:0] m_rf [32];

  function automatic void add(input logic [31:0] mask, input logic [31:0] match,
                              input mnem_e mn, input int fmt);
    pat_t p;
    p.mask = mask; p.match = match; p.mn = mn; p.fmt = fmt;
    pats.push_back(p);
  endfunction

  function automatic int lookup(input logic [31:0] x);
    foreach (pats[i]) if ((x & pats[i].mask) == pats[i].match) return i;
    return -1;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] x, input int fmt);
    logic signed [31:0] s;
    s = $signed(x);
    case (fmt)
      1: return 32'(s >>> 20);
      2: return (32'(s >>> 20) & 32'hFFFF_FFE0) | 32'(x[11:7]);
      3: return (32'(s >>> 19) & 32'hFFFF_F000) | (32'(x[7]) << 11) | (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
      4: return x & 32'hFFFF_F000;
      5: return (32'(s >>> 11) & 32'hFFF0_0000) | (32'(x[19:12]) << 12) | (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_hazard();
    int k, f;
    bit u1, u2;
    k = lookup(m_inst);
    f = (k >= 0) ? pats[k].fmt : -1;
    u1 = (f == 0) || (f == 1) || (f == 2) || (f == 3);
    u2 = (f == 0) || (f == 2) || (f == 3);
    return m_hv && ex_load && (ex_rd != 5'd0) &&
           ((u1 && (m_inst[19:15] == ex_rd)) || (u2 && (m_inst[24:20] == ex_rd)));
  endfunction

  function automatic logic [31:0] ref_rs(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef IDU_RF_BYPASS_EN
    if (wb_wr && (wb_addr == a)) return wb_data;
`endif
    return m_rf[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int k, f;
    bit legal, hz;
    k = lookup(m_inst);
    legal = (k >= 0);
    f = legal ? pats[k].fmt : -1;
    hz = ref_hazard();
    chk("valid", 64'(o_valid), 64'(m_hv && !hz));
    chk("ready", 64'(o_ready), 64'(!m_hv || (rdy && !hz)));
    chk("hazard", 64'(o_hazard), 64'(hz));
    chk("pc", 64'(o_pc), 64'(m_pc));
    chk("illegal", 64'(o_illegal), 64'(!legal));
    chk("mnem", 64'(o_mnemonic), legal ? 64'(pats[k].mn) : 64'(ILLEGAL));
    chk("rd_wr", 64'(o_rd_wr), 64'(legal && (f == 0 || f == 1 || f == 4 || f == 5)));
    chk("dm_oe", 64'(o_DM_OE), 64'(legal && (m_inst[6:0] == 7'h03)));
    chk("alusrc1", 64'(o_ALUsrc1), 64'(legal && (m_inst[6:0] == 7'h17 || m_inst[6:0] == 7'h6F)));
    chk("alusrc2", 64'(o_ALUsrc2), 64'(legal && (f == 1 || f == 2 || f == 4 || f == 5)));
    chk("rd_addr", 64'(o_rd_addr), 64'(m_inst[11:7]));
    chk("rs1_addr", 64'(o_rs1_addr), 64'(m_inst[19:15]));
    chk("rs2_addr", 64'(o_rs2_addr), 64'(m_inst[24:20]));
    chk("rs1_data", 64'(o_rs1_data), 64'(ref_rs(m_inst[19:15])));
    chk("rs2_data", 64'(o_rs2_data), 64'(ref_rs(m_inst[24:20])));
    if (legal) chk("imm", 64'(o_imm), 64'(ref_imm(m_inst, f)));
  endtask

  task automatic model_reset();
    m_hv = 1'b0; m_pc = 32'h0; m_inst = NOP;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit hz, ov, ordy;
    @(negedge clk);
    check_model();
    hz = ref_hazard();
    ov = m_hv && !hz;
    ordy = !m_hv || (rdy && !hz);
    @(posedge clk);
    if (flush) m_hv = 1'b0;
    else if (valid && ordy) begin m_hv = 1'b1; m_pc = pc; m_inst = inst; end
    else if (ov && rdy) m_hv = 1'b0;
    if (wb_wr && (wb_addr != 5'd0)) m_rf[wb_addr] = wb_data;
    #1;
  endtask

  initial begin
    int k;
    add(32'h7F, 32'h37, LUI, 4);        add(32'h7F, 32'h17, AUIPC, 4);
    add(32'h7F, 32'h6F, JAL, 5);        add(32'h707F, 32'h67, JALR, 1);
    add(32'h707F, 32'h0063, BEQ, 3);    add(32'h707F, 32'h1063, BNE, 3);
    add(32'h707F, 32'h4063, BLT, 3);    add(32'h707F, 32'h5063, BGE, 3);
    add(32'h707F, 32'h6063, BLTU, 3);   add(32'h707F, 32'h7063, BGEU, 3);
    add(32'h707F, 32'h0003, LB, 1);     add(32'h707F, 32'h1003, LH, 1);
    add(32'h707F, 32'h2003, LW, 1);     add(32'h707F, 32'h4003, LBU, 1);
    add(32'h707F, 32'h5003, LHU, 1);    add(32'h707F, 32'h0023, SB, 2);
    add(32'h707F, 32'h1023, SH, 2);     add(32'h707F, 32'h2023, SW, 2);
    add(32'h707F, 32'h0013, ADDI, 1);   add(32'h707F, 32'h2013, SLTI, 1);
    add(32'h707F, 32'h3013, SLTIU, 1);  add(32'h707F, 32'h4013, XORI, 1);
    add(32'h707F, 32'h6013, ORI, 1);    add(32'h707F, 32'h7013, ANDI, 1);
    add(32'hFE00707F, 32'h00001013, SLLI, 1);
    add(32'hFE00707F, 32'h00005013, SRLI, 1);
    add(32'hFE00707F, 32'h40005013, SRAI, 1);
    add(32'hFE00707F, 32'h00000033, ADD, 0); add(32'hFE00707F, 32'h40000033, SUB, 0);
    add(32'hFE00707F, 32'h00001033, SLL, 0); add(32'hFE00707F, 32'h00002033, SLT, 0);
    add(32'hFE00707F, 32'h00003033, SLTU, 0); add(32'hFE00707F, 32'h00004033, XOR, 0);
    add(32'hFE00707F, 32'h00005033, SRL, 0); add(32'hFE00707F, 32'h40005033, SRA, 0);
    add(32'hFE00707F, 32'h00006033, OR, 0);  add(32'hFE00707F, 32'h00007033, AND, 0);

    rst = 1'b0; valid = 0; flush = 0; rdy = 1; ex_load = 0; wb_wr = 0;
    pc = 0; inst = 0; wb_data = 0; ex_rd = 0; wb_addr = 0;
    model_reset();

    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_hazard", 64'(o_hazard), 64'd0);
    chk("rst_illegal", 64'(o_illegal), 64'd0);
    chk("rst_rd_wr", 64'(o_rd_wr), 64'd1);
    chk("rst_rd", 64'(o_rd_addr), 64'd0);
    chk("rst_mnem", 64'(o_mnemonic), 64'(ADDI));
    @(posedge clk); #1 rst = 1'b1;

    // ADDI x1,x0,5 streams through with one-cycle latency
    valid = 1; pc = 32'h0; inst = 32'h0050_0093;
    cycle();
    chk("t1_valid", 64'(o_valid), 64'd1);
    chk("t1_imm", 64'(o_imm), 64'd5);
    chk("t1_rd", 64'(o_rd_addr), 64'd1);
    chk("t1_rd_wr", 64'(o_rd_wr), 64'd1);
    chk("t1_pc", 64'(o_pc), 64'd0);

    // Back-pressure for three cycles, then release
    pc = 32'h4; inst = 32'h00A0_0113; rdy = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready", 64'(o_ready), 64'd0);
      chk("bp_pc", 64'(o_pc), 64'd0);
      chk("bp_imm", 64'(o_imm), 64'd5);
    end
    rdy = 1;
    cycle();
    chk("rel_pc", 64'(o_pc), 64'h4);
    chk("rel_imm", 64'(o_imm), 64'd10);
    chk("rel_valid", 64'(o_valid), 64'd1);

    // Load-use hazard on ADD x3,x1,x2
    pc = 32'h8; inst = 32'h0020_81B3;
    cycle();
    valid = 0; ex_load = 1; ex_rd = 5'd2; #1;
    chk("hz_hazard", 64'(o_hazard), 64'd1);
    chk("hz_valid", 64'(o_valid), 64'd0);
    chk("hz_ready", 64'(o_ready), 64'd0);
    cycle();
    chk("hz_hold_pc", 64'(o_pc), 64'h8);
    ex_load = 0; #1;
    chk("hz_exit_valid", 64'(o_valid), 64'd1);
    cycle();

    // Flush wins over a simultaneous accept
    valid = 1; pc = 32'hC; inst = 32'h0050_0093;
    cycle();
    pc = 32'h10; inst = 32'h0070_0193; flush = 1;
    cycle();
    chk("fl_valid", 64'(o_valid), 64'd0);
    flush = 0; valid = 0;
    cycle();
    chk("fl_never", 64'(o_valid), 64'd0);

    // Write-back vs read of x5, then writes to x0
    valid = 1; pc = 32'h14; inst = 32'h0002_8313;
    cycle();
    valid = 0; rdy = 0; wb_wr = 1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF; #1;
`ifdef IDU_RF_BYPASS_EN
    chk("byp_same", 64'(o_rs1_data), 64'hDEAD_BEEF);
`else
    chk("byp_same", 64'(o_rs1_data), 64'h0);
`endif
    cycle();
    wb_wr = 0; #1;
    chk("byp_after", 64'(o_rs1_data), 64'hDEAD_BEEF);
    rdy = 1; valid = 1; pc = 32'h18; inst = 32'h0050_0093;
    wb_wr = 1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
    cycle();
    valid = 0; rdy = 0; #1;
    chk("x0_same", 64'(o_rs1_data), 64'h0);
    cycle();
    wb_wr = 0; #1;
    chk("x0_after", 64'(o_rs1_data), 64'h0);

    // Illegal instruction still presented as valid
    rdy = 1; valid = 1; pc = 32'h1C; inst = 32'hFFFF_FFFF;
    cycle();
    valid = 0; #1;
    chk("ill_flag", 64'(o_illegal), 64'd1);
    chk("ill_rd_wr", 64'(o_rd_wr), 64'd0);
    chk("ill_valid", 64'(o_valid), 64'd1);
    chk("ill_mnem", 64'(o_mnemonic), 64'(ILLEGAL));
    cycle();

    // Reset in the middle of a stall
    valid = 1; pc = 32'h20; inst = 32'h0020_81B3;
    cycle();
    valid = 0; ex_load = 1; ex_rd = 5'd1;
    cycle();
    #2 rst = 1'b0;
    #1;
    chk("rst_stall_valid", 64'(o_valid), 64'd0);
    chk("rst_stall_hazard", 64'(o_hazard), 64'd0);
    chk("rst_stall_ready", 64'(o_ready), 64'd1);
    chk("rst_stall_pc", 64'(o_pc), 64'd0);
    model_reset();
    ex_load = 0;
    @(posedge clk); #1 rst = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, pats.size() - 1));
      inst = ($urandom & ~pats[k].mask) | pats[k].match;
      inst[19:15] = 5'($urandom_range(0, 7));
      inst[24:20] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) inst = 32'hFFFF_FFFF;
      pc      = $urandom & 32'hFFFF_FFFC;
      valid   = ($urandom_range(0, 9) < 7);
      rdy     = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      ex_load = ($urandom_range(0, 9) < 3);
      ex_rd   = 5'($urandom_range(0, 7));
      wb_wr   = $urandom_range(0, 1) == 1;
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
